// File: rtl/finite_log.sv
`default_nettype none
// ============================================================================
// Module   : finite_log
// Purpose  : Sequential GF(2^M) discrete logarithm. For a nonzero
//            standard-basis element a, finds k in 0..2^M-2 with alpha^k = a.
//            It walks successive powers of alpha and compares STEPS
//            candidates per clock. A zero operand gives zero_err.
// Ports    : clk          rising-edge clock
//            reset        asynchronous, active-high
//            start        request strobe, accepted only while busy=0
//            standard_in  operand a (M bits), sampled on an accepted start
//            log_out      result k (M bits), held until the next valid
//            busy         search in progress
//            valid        one-cycle pulse: new log_out/zero_err
//            zero_err     pulses with valid when the operand was 0
// Revision : 1.0 - initial release
// ============================================================================
module finite_log #(
  parameter int M     = 4,
  parameter int STEPS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] standard_in,
  output logic [M-1:0] log_out,
  output logic         busy,
  output logic         valid,
  output logic         zero_err
);

  // Primitive field polynomials, indexed by field degree.
  function automatic int bch_polynomial(input int m);
    case (m)
      2:       return 'h7;
      3:       return 'hB;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h89;
      8:       return 'h11D;
      9:       return 'h211;
      10:      return 'h409;
      11:      return 'h805;
      12:      return 'h1053;
      13:      return 'h201B;
      14:      return 'h4443;
      15:      return 'h8003;
      default: return 'h1100B;
    endcase
  endfunction

  localparam logic [M-1:0] POLY_LOW = M'(bch_polynomial(M));
  localparam logic [M:0]   MAX_LOG  = (M+1)'((2**M) - 2);

  // Multiply a standard-basis element by alpha.
  function automatic logic [M-1:0] mul1(input logic [M-1:0] x);
    logic [M-1:0] sh;
    sh = {x[M-2:0], 1'b0};
    return x[M-1] ? (sh ^ POLY_LOW) : sh;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ZERO   = 2'd1,
    S_SEARCH = 2'd2
  } state_t;

  state_t       state;
  logic [M-1:0] target;
  logic [M-1:0] acc;
  logic [M-1:0] base;

  logic [M-1:0] cand [STEPS];
  logic [M:0]   cand_sum;
  logic         hit;
  logic [M-1:0] hit_log;
  logic [M-1:0] acc_step;
  logic         overrun;

  // Chained mul1 network: cand[j] = acc * alpha^j. Exponents past 2^M-2
  // are masked so an overhanging last block cannot alias a small k. The
  // descending scan leaves the lowest matching j in hit_log.
  always_comb begin
    cand[0]  = acc;
    for (int j = 1; j < STEPS; j++) begin
      cand[j] = mul1(cand[j-1]);
    end
    hit      = 1'b0;
    hit_log  = '0;
    cand_sum = '0;
    for (int j = STEPS - 1; j >= 0; j--) begin
      cand_sum = {1'b0, base} + (M+1)'(j);
      if ((cand[j] == target) && (cand_sum <= MAX_LOG)) begin
        hit     = 1'b1;
        hit_log = cand_sum[M-1:0];
      end
    end
    acc_step = mul1(cand[STEPS-1]);
    overrun  = (({1'b0, base} + (M+1)'(STEPS)) > MAX_LOG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      target   <= '0;
      acc      <= M'(1);
      base     <= '0;
      log_out  <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      valid    <= 1'b0;
      zero_err <= 1'b0;
      case (state)
        S_SEARCH: begin
          if (hit) begin
            log_out <= hit_log;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (overrun) begin
            // Whole field scanned without a match: report as undefined.
            log_out  <= '0;
            valid    <= 1'b1;
            zero_err <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            acc  <= acc_step;
            base <= base + M'(STEPS);
          end
        end
        default: begin
          // S_ZERO is a one-cycle delay so a zero operand reports with the
          // same latency as a k < STEPS hit; busy stays low throughout.
          if (state == S_ZERO) begin
            log_out  <= '0;
            valid    <= 1'b1;
            zero_err <= 1'b1;
            state    <= S_IDLE;
          end
          if (start) begin
            target <= standard_in;
            if (standard_in == '0) begin
              state <= S_ZERO;
            end else begin
              acc   <= M'(1);
              base  <= '0;
              busy  <= 1'b1;
              state <= S_SEARCH;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_finite_log.sv
`default_nettype none
// ============================================================================
// Module   : tb_finite_log
// Purpose  : Self-checking bench for finite_log. Five instances cover
//            (M,STEPS) = (4,1) (4,4) (5,1) (5,3) (5,31). Results are checked
//            against a power-table model of the field.
// Revision : 1.0 - initial release
// ============================================================================
module tb_finite_log;

  localparam int NI = 5;

  function automatic int m_of(input int i);
    return (i < 2) ? 4 : 5;
  endfunction

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 1 : (i == 3) ? 3 : 31;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_v [NI];
  logic [4:0] din     [NI];
  logic [4:0] lo      [NI];
  logic       busy_v  [NI];
  logic       valid_v [NI];
  logic       zerr_v  [NI];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MI = m_of(g);
    localparam int SI = s_of(g);
    logic [MI-1:0] din_w;
    logic [MI-1:0] lo_w;
    assign din_w = din[g][MI-1:0];
    assign lo[g] = 5'(lo_w);
    finite_log #(.M(MI), .STEPS(SI)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .standard_in(din_w),
      .log_out    (lo_w),
      .busy       (busy_v[g]),
      .valid      (valid_v[g]),
      .zero_err   (zerr_v[g])
    );
  end

  // Field model: walk alpha^k by plain shift-and-reduce until it equals a.
  function automatic int poly_of(input int m);
    return (m == 4) ? 'h13 : 'h25;
  endfunction

  function automatic int ref_log(input int m, input int a);
    int p;
    p = 1;
    for (int k = 0; k <= (1 << m) - 2; k++) begin
      if (p == a) return k;
      p = p << 1;
      if (((p >> m) & 1) != 0) p = p ^ poly_of(m);
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the valid cycle so the
  // caller may issue the next start immediately (back-to-back).
  task automatic run_op(input int i, input int a, input bit interfere);
    int m, s, k, exp_lat, c;
    m       = m_of(i);
    s       = s_of(i);
    k       = (a == 0) ? 0 : ref_log(m, a);
    exp_lat = (a == 0) ? 1 : 1 + k / s;
    c       = 0;
    start_v[i] = 1'b1;
    din[i]     = 5'(a);
    @(posedge clk);
    #1 start_v[i] = 1'b0;
    while (c < 40) begin
      @(posedge clk);
      c++;
      #1 start_v[i] = 1'b0;
      @(negedge clk);
      if (valid_v[i]) break;
      check($sformatf("i%0d a=%0d busy_during", i, a), 32'(busy_v[i]), 32'(a != 0));
      if (interfere && c == 1) begin
        start_v[i] = 1'b1;
        din[i]     = 5'd1;
      end
    end
    check($sformatf("i%0d a=%0d valid_seen", i, a), 32'(valid_v[i]), 32'd1);
    check($sformatf("i%0d a=%0d latency", i, a), 32'(c), 32'(exp_lat));
    check($sformatf("i%0d a=%0d log_out", i, a), 32'(lo[i]), 32'(k));
    check($sformatf("i%0d a=%0d zero_err", i, a), 32'(zerr_v[i]), 32'(a == 0));
    check($sformatf("i%0d a=%0d busy_at_valid", i, a), 32'(busy_v[i]), 32'd0);
  endtask

  task automatic idle_check(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      check($sformatf("i%0d idle_valid", i), 32'(valid_v[i]), 32'd0);
      check($sformatf("i%0d idle_zerr", i), 32'(zerr_v[i]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      din[i]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d reset_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("i%0d reset_valid", i), 32'(valid_v[i]), 32'd0);
      check($sformatf("i%0d reset_zerr", i), 32'(zerr_v[i]), 32'd0);
      check($sformatf("i%0d reset_log", i), 32'(lo[i]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed M=4 cases.
    run_op(0, 4'b0001, 1'b0);
    idle_check(0, 2);
    run_op(0, 4'b1001, 1'b0);
    run_op(1, 4'b1001, 1'b0);
    run_op(1, 4'b0011, 1'b0);
    run_op(0, 0, 1'b0);
    idle_check(0, 1);
    run_op(0, 4'b1000, 1'b1);
    idle_check(0, 2);

    // Full back-to-back sweeps on the M=5 instances, then a zero operand.
    for (int i = 2; i < NI; i++) begin
      for (int a = 1; a < 32; a++) run_op(i, a, 1'b0);
      run_op(i, 0, 1'b0);
      idle_check(i, 2);
    end

    // Random operands on random instances, mixing back-to-back and gaps.
    for (int n = 0; n < 60; n++) begin
      int i, a;
      i = int'($urandom_range(0, NI - 1));
      a = int'($urandom_range(0, (1 << m_of(i)) - 1));
      run_op(i, a, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check(i, int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a long search aborts it without a result.
    start_v[0] = 1'b1;
    din[0]     = 5'b01001;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy_before_reset", 32'(busy_v[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort busy_now", 32'(busy_v[0]), 32'd0);
    check("abort valid_now", 32'(valid_v[0]), 32'd0);
    check("abort log_cleared", 32'(lo[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_check(0, 20);
    run_op(0, 4'b0011, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
